ret_addr_stack: RTL and testbench
=================================

Name: ret_addr_stack

Overview:
- Parametrised branch/return-address unit for the pipelined CPU; next generation of the single-entry link register.
- Decodes branch-class opcodes (BR, BRZ, BRN, CALL, RET) and computes the next fetch address.
- Holds a DEPTH-entry return-address stack so subroutine calls can nest.
- Reports stack occupancy and overflow/underflow errors.

Parameters:
ADDR_W, 8, width of PC, target and return addresses
DEPTH, 4, number of return-stack entries (power of 2, >=2)
STEP, 2, PC increment for fall-through and return (instruction size in address units)
WRAP_MODE, 1, 1 = a push when full overwrites the oldest entry; 0 = a push when full is dropped

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  opcode/pc/target are valid this cycle
pc  in  ADDR_W  address of the current instruction
opcode  in  4  instruction[15:12]
cond_sel  in  1  instruction[11]: 0 = test Z, 1 = test N
target  in  ADDR_W  branch/call target field
Z  in  1  zero flag
N  in  1  negative flag
err_clr  in  1  clears the sticky error flags
next_pc  out  ADDR_W  computed next fetch address
next_valid  out  1  one-cycle pulse: next_pc was updated this cycle
taken  out  1  one-cycle pulse: the update was a redirect (not fall-through)
depth  out  $clog2(DEPTH)+1  current stack occupancy, 0..DEPTH
overflow  out  1  sticky: a push occurred while full
underflow  out  1  sticky: a RET occurred while empty

Behaviour:
- Reset (rst=1 at a clk edge):
  - next_pc=0, next_valid=0, taken=0, depth=0, overflow=0, underflow=0.
  - Stack pointer returns to 0; stack contents are don't-care.
  - Reset wins over any concurrent instruction or err_clr.
- All outputs are registered. Latency is 1 cycle from instr_valid to next_valid/next_pc.
- next_valid and taken default to 0 each cycle. next_pc holds its value when not updated.
- instr_valid=0 or a non-branch opcode: no state change; next_valid=0.
- Opcode 4'b1001 BR: next_pc=target, next_valid=1, taken=1.
- Opcode 4'b1010 conditional branch:
  - Condition is Z when cond_sel=0, N when cond_sel=1.
  - Condition true: next_pc=target, taken=1.
  - Condition false: next_pc=pc+STEP, taken=0.
  - next_valid=1 in both cases.
- Opcode 4'b1011 CALL: push pc; next_pc=target, next_valid=1, taken=1.
  - Not full: write stack[sp], sp++, depth++.
  - Full, WRAP_MODE=1: overwrite oldest entry, advance sp circularly, depth stays DEPTH, overflow=1.
  - Full, WRAP_MODE=0: push discarded, sp/depth unchanged, overflow=1. The jump is still taken.
- Opcode 4'b1100 RET:
  - Not empty: pop top; next_pc=top+STEP, sp--, depth--, next_valid=1, taken=1.
  - Empty: next_pc unchanged, next_valid=0, taken=0, underflow=1.
- Arithmetic: pc+STEP and top+STEP are modulo 2^ADDR_W, so wrap-around is silent.
- Stack pointer is log2(DEPTH) bits wide and wraps circularly.
- Flags are sticky until err_clr=1 or rst.
  - err_clr and a new error event in the same cycle: the flag ends at 1 (set wins over clear).
- Only one stack operation per cycle, since the opcode is unique.
- Reset mid-sequence discards all pending return addresses.
- Opcodes 4'b1101 to 4'b1111 and all non-branch codes: ignored.

Test Plan:
- BR/cond: BR target=0x40 -> next cycle next_pc=0x40, taken=1. Cond, cond_sel=0, Z=0, pc=0x10 -> next_pc=0x12, taken=0, next_valid=1. Cond, cond_sel=1, N=1, target=0x55 -> next_pc=0x55, taken=1.
- Nested calls: CALL pc=0x10 ->0x30; CALL pc=0x32 ->0x50; RET -> next_pc=0x34; RET -> next_pc=0x12. depth goes 1,2,1,0.
- Overflow, WRAP_MODE=1, DEPTH=4: five CALLs at pc=0x00,0x02,0x04,0x06,0x08 -> overflow=1, depth=4. Four RETs return 0x0A,0x08,0x06,0x04. Fifth RET -> underflow=1, next_valid=0.
- Overflow, WRAP_MODE=0: same five CALLs -> fifth push dropped. RETs return 0x08,0x06,0x04,0x02.
- Sticky flags: underflow set, then err_clr=1 with no error -> underflow=0. err_clr asserted in the same cycle as a RET on empty -> underflow stays 1.
- Wrap/reset: RET with top=0xFF, ADDR_W=8 -> next_pc=0x01. rst asserted after two CALLs -> depth=0, next_pc=0. A following RET -> underflow=1.

Source files
------------

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: branch/return-address unit with a DEPTH-entry return-address stack.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   i_instr_valid             i_pc/i_opcode/i_target are valid this cycle
//   i_pc, i_target            current instruction address and branch/call target
//   i_opcode, i_cond_sel      instruction[15:12] and instruction[11] (0 = Z, 1 = N)
//   i_z, i_n                  condition flags
//   i_err_clr                 clears the sticky error flags
//   o_next_pc                 next fetch address (holds when not updated)
//   o_next_valid, o_taken     one-cycle pulses: next_pc updated / update was a redirect
//   o_depth                   stack occupancy 0..DEPTH
//   o_overflow, o_underflow   sticky push-while-full / RET-while-empty flags
module ret_addr_stack #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 4,
    parameter int STEP      = 2,
    parameter int WRAP_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_instr_valid,
    input  logic [ADDR_W-1:0]        i_pc,
    input  logic [3:0]               i_opcode,
    input  logic                     i_cond_sel,
    input  logic [ADDR_W-1:0]        i_target,
    input  logic                     i_z,
    input  logic                     i_n,
    input  logic                     i_err_clr,
    output logic [ADDR_W-1:0]        o_next_pc,
    output logic                     o_next_valid,
    output logic                     o_taken,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_overflow,
    output logic                     o_underflow
);
    localparam int SP_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_stack [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [SP_W:0]     r_depth;
    logic [ADDR_W-1:0] r_next_pc;
    logic              r_next_valid;
    logic              r_taken;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_br;
    logic              w_cnd;
    logic              w_call;
    logic              w_ret;
    logic              w_cond;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_step;

    assign w_br    = i_instr_valid && (i_opcode == 4'b1001);
    assign w_cnd   = i_instr_valid && (i_opcode == 4'b1010);
    assign w_call  = i_instr_valid && (i_opcode == 4'b1011);
    assign w_ret   = i_instr_valid && (i_opcode == 4'b1100);
    assign w_cond  = i_cond_sel ? i_n : i_z;
    assign w_full  = r_depth == (SP_W+1)'(DEPTH);
    assign w_empty = r_depth == '0;
    // sp points at the next free slot, so the top of stack sits one below it
    assign w_top   = r_stack[r_sp - 1'b1];
    assign w_step  = ADDR_W'(STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp         <= '0;
            r_depth      <= '0;
            r_next_pc    <= '0;
            r_next_valid <= 1'b0;
            r_taken      <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_next_valid <= 1'b0;
            r_taken      <= 1'b0;
            // clear first so that a same-cycle error below wins
            if (i_err_clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            if (w_br) begin
                r_next_pc    <= i_target;
                r_next_valid <= 1'b1;
                r_taken      <= 1'b1;
            end
            if (w_cnd) begin
                r_next_pc    <= w_cond ? i_target : i_pc + w_step;
                r_next_valid <= 1'b1;
                r_taken      <= w_cond;
            end
            if (w_call) begin
                r_next_pc    <= i_target;
                r_next_valid <= 1'b1;
                r_taken      <= 1'b1;
                if (!w_full) begin
                    r_stack[r_sp] <= i_pc;
                    r_sp          <= r_sp + 1'b1;
                    r_depth       <= r_depth + 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                    // when full, sp already addresses the oldest entry
                    if (WRAP_MODE != 0) begin
                        r_stack[r_sp] <= i_pc;
                        r_sp          <= r_sp + 1'b1;
                    end
                end
            end
            if (w_ret) begin
                if (!w_empty) begin
                    r_next_pc    <= w_top + w_step;
                    r_sp         <= r_sp - 1'b1;
                    r_depth      <= r_depth - 1'b1;
                    r_next_valid <= 1'b1;
                    r_taken      <= 1'b1;
                end else begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    assign o_next_pc    = r_next_pc;
    assign o_next_valid = r_next_valid;
    assign o_taken      = r_taken;
    assign o_depth      = r_depth;
    assign o_overflow   = r_overflow;
    assign o_underflow  = r_underflow;
endmodule

// File: tb/tb_ret_addr_stack.sv
// tb_ret_addr_stack: self-checking bench for ret_addr_stack in both WRAP_MODE settings.
module tb_ret_addr_stack;
    logic       clk = 1'b0;
    logic       rst, valid, cs, z, n, clr;
    logic [7:0] pc, tg;
    logic [3:0] op;

    logic [7:0] npc1, npc0;
    logic       nv1, nv0, tk1, tk0, ovf1, ovf0, unf1, unf0;
    logic [2:0] dep1, dep0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ret_addr_stack #(.ADDR_W(8), .DEPTH(4), .STEP(2), .WRAP_MODE(1)) u_w1 (
        .clk(clk), .rst(rst), .i_instr_valid(valid), .i_pc(pc), .i_opcode(op),
        .i_cond_sel(cs), .i_target(tg), .i_z(z), .i_n(n), .i_err_clr(clr),
        .o_next_pc(npc1), .o_next_valid(nv1), .o_taken(tk1), .o_depth(dep1),
        .o_overflow(ovf1), .o_underflow(unf1));

    ret_addr_stack #(.ADDR_W(8), .DEPTH(4), .STEP(2), .WRAP_MODE(0)) u_w0 (
        .clk(clk), .rst(rst), .i_instr_valid(valid), .i_pc(pc), .i_opcode(op),
        .i_cond_sel(cs), .i_target(tg), .i_z(z), .i_n(n), .i_err_clr(clr),
        .o_next_pc(npc0), .o_next_valid(nv0), .o_taken(tk0), .o_depth(dep0),
        .o_overflow(ovf0), .o_underflow(unf0));

    typedef struct {
        logic       rst, v;
        logic [7:0] pc;
        logic [3:0] op;
        logic       cs;
        logic [7:0] tg;
        logic       z, n, clr;
        logic [7:0] e_npc;
        logic       e_nv, e_tk;
        logic [2:0] e_dep;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic v, logic [7:0] p, logic [3:0] o, logic c,
                                logic [7:0] t, logic zz, logic nn, logic cl,
                                logic [7:0] enpc, logic env, logic etk, logic [2:0] edep,
                                logic eovf, logic eunf);
        vec_t x;
        x.rst = r; x.v = v; x.pc = p; x.op = o; x.cs = c; x.tg = t; x.z = zz; x.n = nn;
        x.clr = cl; x.e_npc = enpc; x.e_nv = env; x.e_tk = etk; x.e_dep = edep;
        x.e_ovf = eovf; x.e_unf = eunf;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [7:0] p, input logic [3:0] o,
                         input logic c, input logic [7:0] t, input logic zz, input logic nn,
                         input logic cl);
        rst = r; valid = v; pc = p; op = o; cs = c; tg = t; z = zz; n = nn; clr = cl;
    endtask

    // Reference model: the stack is a plain array with the oldest entry at index 0.
    logic [7:0] ms [2][4];
    int         mcnt [2];
    logic [7:0] m_npc [2];
    logic       m_nv [2], m_tk [2], m_ovf [2], m_unf [2];

    task automatic mstep(input int m);
        logic c;
        if (rst) begin
            m_npc[m] = 8'h00; m_nv[m] = 0; m_tk[m] = 0; mcnt[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
            return;
        end
        m_nv[m] = 0; m_tk[m] = 0;
        if (clr) begin m_ovf[m] = 0; m_unf[m] = 0; end
        if (!valid) return;
        case (op)
            4'd9: begin m_npc[m] = tg; m_nv[m] = 1; m_tk[m] = 1; end
            4'd10: begin
                c = cs ? n : z;
                m_npc[m] = c ? tg : pc + 8'd2;
                m_nv[m] = 1; m_tk[m] = c;
            end
            4'd11: begin
                m_npc[m] = tg; m_nv[m] = 1; m_tk[m] = 1;
                if (mcnt[m] < 4) begin
                    ms[m][mcnt[m]] = pc;
                    mcnt[m]++;
                end else begin
                    m_ovf[m] = 1;
                    if (m == 1) begin
                        for (int k = 0; k < 3; k++) ms[m][k] = ms[m][k+1];
                        ms[m][3] = pc;
                    end
                end
            end
            4'd12: begin
                if (mcnt[m] > 0) begin
                    mcnt[m]--;
                    m_npc[m] = ms[m][mcnt[m]] + 8'd2;
                    m_nv[m] = 1; m_tk[m] = 1;
                end else m_unf[m] = 1;
            end
            default: ;
        endcase
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        //              rst v  pc     op  cs tg     z  n  clr  npc    nv tk dep ovf unf
        tv.push_back(mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0,   8'h00, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 9,  0, 8'h40, 0, 0, 0,   8'h40, 1, 1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h10, 10, 0, 8'h77, 0, 1, 0,   8'h12, 1, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h20, 10, 1, 8'h55, 0, 1, 0,   8'h55, 1, 1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h20, 10, 0, 8'h66, 1, 0, 0,   8'h66, 1, 1, 0, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 9,  0, 8'h99, 0, 0, 0,   8'h66, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 3,  0, 8'h99, 0, 0, 0,   8'h66, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 13, 0, 8'h99, 0, 0, 0,   8'h66, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h10, 11, 0, 8'h30, 0, 0, 0,   8'h30, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 1, 8'h32, 11, 0, 8'h50, 0, 0, 0,   8'h50, 1, 1, 2, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0,   8'h34, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0,   8'h12, 1, 1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0,   8'h12, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 1,   8'h12, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 1,   8'h12, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0, 1,   8'h12, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'hFF, 11, 0, 8'h20, 0, 0, 0,   8'h20, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0,   8'h01, 1, 1, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h10, 11, 0, 8'h30, 0, 0, 0,   8'h30, 1, 1, 1, 0, 0));
        tv.push_back(mk(0, 1, 8'h12, 11, 0, 8'h40, 0, 0, 0,   8'h40, 1, 1, 2, 0, 0));
        tv.push_back(mk(1, 1, 8'h14, 11, 0, 8'h50, 0, 0, 0,   8'h00, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0,   8'h00, 0, 0, 0, 0, 1));
        tv.push_back(mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0, 0,   8'h00, 0, 0, 0, 0, 0));

        @(posedge clk); #1;
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].v, tv[i].pc, tv[i].op, tv[i].cs, tv[i].tg, tv[i].z, tv[i].n, tv[i].clr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d npc", i), 32'(npc1), 32'(tv[i].e_npc));
            chk($sformatf("vec%0d nv", i), 32'(nv1), 32'(tv[i].e_nv));
            chk($sformatf("vec%0d tk", i), 32'(tk1), 32'(tv[i].e_tk));
            chk($sformatf("vec%0d dep", i), 32'(dep1), 32'(tv[i].e_dep));
            chk($sformatf("vec%0d ovf", i), 32'(ovf1), 32'(tv[i].e_ovf));
            chk($sformatf("vec%0d unf", i), 32'(unf1), 32'(tv[i].e_unf));
            chk($sformatf("vec%0d npc_w0", i), 32'(npc0), 32'(tv[i].e_npc));
            chk($sformatf("vec%0d dep_w0", i), 32'(dep0), 32'(tv[i].e_dep));
        end

        // Five CALLs into a 4-deep stack, then unwind both wrap policies.
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 8'(2*i), 11, 0, 8'h80, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("ovcall%0d dep", i), 32'(dep1), (i < 4) ? i + 1 : 4);
            chk($sformatf("ovcall%0d ovf", i), 32'(ovf1), 32'(i == 4));
            chk($sformatf("ovcall%0d dep_w0", i), 32'(dep0), (i < 4) ? i + 1 : 4);
            chk($sformatf("ovcall%0d ovf_w0", i), 32'(ovf0), 32'(i == 4));
            chk($sformatf("ovcall%0d npc", i), 32'(npc1), 32'h80);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0);
            @(posedge clk); #1;
            chk($sformatf("ovret%0d npc_w1", i), 32'(npc1), 32'h0A - 2*i);
            chk($sformatf("ovret%0d npc_w0", i), 32'(npc0), 32'h08 - 2*i);
            chk($sformatf("ovret%0d dep", i), 32'(dep1), 3 - i);
            chk($sformatf("ovret%0d ovf", i), 32'(ovf1), 1);
        end
        drive(0, 1, 8'h00, 12, 0, 8'h00, 0, 0, 0);
        @(posedge clk); #1;
        chk("ovret4 unf_w1", 32'(unf1), 1);
        chk("ovret4 nv_w1", 32'(nv1), 0);
        chk("ovret4 npc_w1", 32'(npc1), 32'h04);
        chk("ovret4 unf_w0", 32'(unf0), 1);
        chk("ovret4 npc_w0", 32'(npc0), 32'h02);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive((i == 0) || ($urandom_range(0, 59) == 0), $urandom_range(0, 7) != 0,
                  8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(9, 12)),
                  1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
            mstep(0);
            mstep(1);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d npc_w1", i), 32'(npc1), 32'(m_npc[1]));
            chk($sformatf("rnd%0d nv_w1", i), 32'(nv1), 32'(m_nv[1]));
            chk($sformatf("rnd%0d tk_w1", i), 32'(tk1), 32'(m_tk[1]));
            chk($sformatf("rnd%0d dep_w1", i), 32'(dep1), 32'(mcnt[1]));
            chk($sformatf("rnd%0d ovf_w1", i), 32'(ovf1), 32'(m_ovf[1]));
            chk($sformatf("rnd%0d unf_w1", i), 32'(unf1), 32'(m_unf[1]));
            chk($sformatf("rnd%0d npc_w0", i), 32'(npc0), 32'(m_npc[0]));
            chk($sformatf("rnd%0d nv_w0", i), 32'(nv0), 32'(m_nv[0]));
            chk($sformatf("rnd%0d tk_w0", i), 32'(tk0), 32'(m_tk[0]));
            chk($sformatf("rnd%0d dep_w0", i), 32'(dep0), 32'(mcnt[0]));
            chk($sformatf("rnd%0d ovf_w0", i), 32'(ovf0), 32'(m_ovf[0]));
            chk($sformatf("rnd%0d unf_w0", i), 32'(unf0), 32'(m_unf[0]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
